// File: rtl/gf180mcu_osu_sc_pkg.sv
// Shared helpers for the gf180mcu OSU 12-track behavioural macros:
// width functions and fall-through mode constants.
package gf180mcu_osu_sc_pkg;

  localparam int FT_OFF = 0;
  localparam int FT_ON  = 1;

  // Pointer width; at least one bit, even for a single-entry buffer.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of a counter that must represent 0..n inclusive.
  function automatic int level_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_12t_buf_fifo_ctrl.sv
// Pointer, occupancy and handshake control for the elastic buffer.
// Pointers wrap at DEPTH-1, so DEPTH need not be a power of two.
module gf180mcu_osu_sc_12t_buf_fifo_ctrl
  import gf180mcu_osu_sc_pkg::*;
#(
  parameter int DEPTH       = 2,
  parameter int FALLTHROUGH = FT_OFF,
  parameter int PW          = clog2_min1(DEPTH),
  parameter int LW          = level_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rn,
  input  logic          a_valid,
  input  logic          y_ready,
  output logic          a_ready,
  output logic          y_valid,
  output logic          push,
  output logic          bypass,
  output logic [PW-1:0] wp,
  output logic [PW-1:0] rp,
  output logic [LW-1:0] level
);

  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [LW-1:0] level_q, level_d;
  logic          empty;
  logic          full;
  logic          pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake generation and next-state for pointers and occupancy; a word
  // that falls through to a ready consumer is never stored.
  always_comb begin
    empty   = (level_q == '0);
    full    = (level_q == LW'(DEPTH));
    a_ready = rn & ~full;
    bypass  = (FALLTHROUGH == FT_ON) & empty & a_valid & rn;
    y_valid = rn & (~empty | bypass);
    push    = a_valid & a_ready & ~(bypass & y_ready);
    pop     = y_valid & y_ready & ~empty;
    wp_d    = push ? next_ptr(wp_q) : wp_q;
    rp_d    = pop ? next_ptr(rp_q) : rp_q;
    level_d = level_q;
    if (push & ~pop) begin
      level_d = level_q + LW'(1);
    end else if (pop & ~push) begin
      level_d = level_q - LW'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rn) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
    end
  end

  assign wp    = wp_q;
  assign rp    = rp_q;
  assign level = level_q;

endmodule

// File: rtl/gf180mcu_osu_sc_12t_buf_fifo.sv
// Parametrised valid/ready elastic buffer: storage array, output mux with
// zero masking and the optional empty-buffer bypass around the control.
module gf180mcu_osu_sc_12t_buf_fifo
  import gf180mcu_osu_sc_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int DEPTH       = 2,
  parameter int FALLTHROUGH = FT_OFF
) (
  input  logic                          CLK,
  input  logic                          RN,
  input  logic [WIDTH-1:0]              A,
  input  logic                          A_VALID,
  output logic                          A_READY,
  output logic [WIDTH-1:0]              Y,
  output logic                          Y_VALID,
  input  logic                          Y_READY,
  output logic [level_width(DEPTH)-1:0] LEVEL
);

  localparam int PW = clog2_min1(DEPTH);
  localparam int LW = level_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] y_data;
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic             push;
  logic             bypass;

  gf180mcu_osu_sc_12t_buf_fifo_ctrl #(
    .DEPTH       (DEPTH),
    .FALLTHROUGH (FALLTHROUGH),
    .PW          (PW),
    .LW          (LW)
  ) u_ctrl (
    .clk     (CLK),
    .rn      (RN),
    .a_valid (A_VALID),
    .y_ready (Y_READY),
    .a_ready (A_READY),
    .y_valid (Y_VALID),
    .push    (push),
    .bypass  (bypass),
    .wp      (wp),
    .rp      (rp),
    .level   (LEVEL)
  );

  // Write the accepted word into the slot at the write pointer.
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wp] = A;
    end
  end

  // Storage array; deliberately left unreset.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  // Select stored head or bypassed input, and force zero when not valid.
  always_comb begin
    y_data = bypass ? A : mem_q[rp];
    Y      = Y_VALID ? y_data : '0;
  end

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_buf_fifo.sv
// Scoreboard bench: one registered and one fall-through buffer (WIDTH=8,
// DEPTH=3) share stimulus; each has its own queue-based reference model.
module tb_gf180mcu_osu_sc_12t_buf_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;

  logic             clk = 1'b0;
  logic             rn;
  logic             a_valid;
  logic             y_ready;
  logic [WIDTH-1:0] a_in;

  logic             a_ready   [2];
  logic             y_valid   [2];
  logic [WIDTH-1:0] y_out     [2];
  logic [1:0]       level_out [2];

  logic [WIDTH-1:0] exp_q [2][$];
  bit               last_accept [2];
  int               pop_count [2] = '{0, 0};
  int               check_count = 0;
  int               error_count = 0;

  // Free-running clock.
  always #5 clk = ~clk;

  gf180mcu_osu_sc_12t_buf_fifo #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .FALLTHROUGH (0)
  ) dut0 (
    .CLK     (clk),
    .RN      (rn),
    .A       (a_in),
    .A_VALID (a_valid),
    .A_READY (a_ready[0]),
    .Y       (y_out[0]),
    .Y_VALID (y_valid[0]),
    .Y_READY (y_ready),
    .LEVEL   (level_out[0])
  );

  gf180mcu_osu_sc_12t_buf_fifo #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .FALLTHROUGH (1)
  ) dut1 (
    .CLK     (clk),
    .RN      (rn),
    .A       (a_in),
    .A_VALID (a_valid),
    .A_READY (a_ready[1]),
    .Y       (y_out[1]),
    .Y_VALID (y_valid[1]),
    .Y_READY (y_ready),
    .LEVEL   (level_out[1])
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_count++;
    if (actual != expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [WIDTH-1:0] a, input logic yr);
    @(posedge clk);
    #1;
    rn      = r;
    a_valid = v;
    a_in    = a;
    y_ready = yr;
  endtask

  // Producer side: check status outputs against the model occupancy, then
  // enqueue every word the model says is accepted this cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int sz;
      bit exp_ready;
      bit exp_valid;
      sz        = exp_q[d].size();
      exp_ready = rn && (sz < DEPTH);
      exp_valid = rn && ((sz > 0) || ((d == 1) && a_valid));
      checkOutput($sformatf("dut%0d.level", d), int'(level_out[d]), sz);
      checkOutput($sformatf("dut%0d.a_ready", d), int'(a_ready[d]), int'(exp_ready));
      checkOutput($sformatf("dut%0d.y_valid", d), int'(y_valid[d]), int'(exp_valid));
      last_accept[d] = a_valid && exp_ready;
      if (last_accept[d]) exp_q[d].push_back(a_in);
      if (!rn) exp_q[d].delete();
    end
  end

  // Monitor side: whenever a DUT presents a word, compare with the queue head
  // and retire it on a handshake; an idle output must read as zero.
  always @(negedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      if (y_valid[d]) begin
        if (exp_q[d].size() == 0) begin
          checkOutput($sformatf("dut%0d.spurious", d), int'(y_out[d]), -1);
        end else begin
          checkOutput($sformatf("dut%0d.y", d), int'(y_out[d]), int'(exp_q[d][0]));
          if (y_ready) begin
            void'(exp_q[d].pop_front());
            pop_count[d]++;
          end
        end
      end else begin
        checkOutput($sformatf("dut%0d.y_masked", d), int'(y_out[d]), 0);
      end
    end
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    int idx;
    int snap0;
    rn      = 1'b0;
    a_valid = 1'b1;
    a_in    = 8'hE1;
    y_ready = 1'b0;

    // Reset held two cycles with a pending write, then released.
    applyStimulus(1'b0, 1'b1, 8'hE2, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);

    // Fill to capacity, try one more, then drain.
    applyStimulus(1'b1, 1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h22, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h33, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h44, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h44, 1'b0);
    repeat (5) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);

    // Simultaneous push and pop at two stored words.
    applyStimulus(1'b1, 1'b1, 8'h55, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h66, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hAA, 1'b1);
    repeat (4) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);

    // Fall-through consume, then fall-through with a stalled consumer.
    applyStimulus(1'b1, 1'b1, 8'h5A, 1'b1);
    repeat (3) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'h5A, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);

    // Reset with two words stored; they must never emerge.
    applyStimulus(1'b1, 1'b1, 8'hC1, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hC2, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'hC3, 1'b1);
    repeat (2) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'hD0, 1'b1);
    repeat (4) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);

    // Wrap-around: ten sequential words with random valid/ready.
    snap0 = pop_count[0];
    idx   = 0;
    for (int c = 0; c < 300 && idx < 10; c++) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 8'(idx), 1'($urandom_range(0, 1)));
      @(negedge clk);
      #2;
      if (last_accept[0]) idx++;
    end
    checkOutput("wrap.accepted", idx, 10);
    repeat (6) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkOutput("wrap.popped", pop_count[0] - snap0, 10);
    checkOutput("wrap.dut0_empty", exp_q[0].size(), 0);
    checkOutput("wrap.dut1_empty", exp_q[1].size(), 0);

    // Random traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      applyStimulus(1'($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)),
                    8'($urandom), 1'($urandom_range(0, 1)));
    end
    repeat (6) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkOutput("rand.dut0_empty", exp_q[0].size(), 0);
    checkOutput("rand.dut1_empty", exp_q[1].size(), 0);

    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
